// File: rtl/bitbang_link_ctrl_if.sv
// Bus bundle for bitbang_link_ctrl: the write-byte stream to the work loader
// and the two result requesters feeding the read lane.
//
// Handshake: a requester holds reqN_valid high with reqN_data stable until the
// controller returns a single-cycle reqN_ready pulse; that pulse means the byte
// was consumed and the requester pops it. wr_valid is a one-cycle push with no
// back-pressure: the loader must take wr_data/wr_last in that cycle.
interface bitbang_link_ctrl_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_last;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;

  // System side: work loader plus result requesters.
  modport master (
    input  wr_data, wr_valid, wr_last, req0_ready, req1_ready,
    output req0_valid, req0_data, req1_valid, req1_data
  );

  // Link controller side.
  modport slave (
    output wr_data, wr_valid, wr_last, req0_ready, req1_ready,
    input  req0_valid, req0_data, req1_valid, req1_data
  );
endinterface

// File: rtl/bitbang_link_ctrl.sv
// bitbang_link_ctrl: host bit-bang link controller.
// Synchronizes RxD/RxC/TxC/RxTxR, assembles LSB-first write bytes, and serves
// the read lane as slots of {presence bit, 8 data bits} with round-robin
// arbitration between two requesters.
// Optional macro BITBANG_LINK_STATS_EN adds rx/tx byte counters.
module bitbang_link_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BYTES  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rxd,
  input  logic i_rxc,
  input  logic i_rxtxr,
  input  logic i_txc,
  output logic o_txd,
  output logic o_link_reset,
  output logic o_tx_state,
`ifdef BITBANG_LINK_STATS_EN
  output logic [15:0] o_rx_byte_cnt,
  output logic [15:0] o_tx_byte_cnt,
`endif
  bitbang_link_ctrl_if.slave bus
);

  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic {TX_IDLE = 1'b0, TX_DATA = 1'b1} tx_state_t;

  logic [SYNC_STAGES-1:0] r_rxd_sync, r_rxc_sync, r_txc_sync, r_rxtxr_sync;
  logic r_rxc_d, r_txc_d, r_rxtxr_d;
  logic w_rxd, w_rxc_rise, w_txc_rise, w_lr, w_lr_fall;

  logic [2:0]    r_rx_bit_cnt;
  logic [BW-1:0] r_rx_byte_cnt;
  logic [7:0]    r_rx_shift, r_wr_data;
  logic          r_wr_valid, r_wr_last, r_link_reset;
  logic [7:0]    w_rx_shift_next;

  tx_state_t r_tx_state, w_tx_state_next;
  logic [7:0] r_tx_shift, w_tx_shift_next;
  logic [2:0] r_tx_bit_cnt, w_tx_bit_cnt_next;
  logic       r_txd, w_txd_next;
  logic       r_req0_ready, r_req1_ready, w_req0_ready_next, w_req1_ready_next;
  logic       r_last_grant, w_last_grant_next;
  logic       w_pick1;

  // Pin synchronizers plus one extra flop per strobe for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxd_sync   <= '0;
      r_rxc_sync   <= '0;
      r_txc_sync   <= '0;
      r_rxtxr_sync <= '0;
      r_rxc_d      <= 1'b0;
      r_txc_d      <= 1'b0;
      r_rxtxr_d    <= 1'b0;
    end else begin
      r_rxd_sync   <= {r_rxd_sync[SYNC_STAGES-2:0], i_rxd};
      r_rxc_sync   <= {r_rxc_sync[SYNC_STAGES-2:0], i_rxc};
      r_txc_sync   <= {r_txc_sync[SYNC_STAGES-2:0], i_txc};
      r_rxtxr_sync <= {r_rxtxr_sync[SYNC_STAGES-2:0], i_rxtxr};
      r_rxc_d      <= r_rxc_sync[SYNC_STAGES-1];
      r_txc_d      <= r_txc_sync[SYNC_STAGES-1];
      r_rxtxr_d    <= r_rxtxr_sync[SYNC_STAGES-1];
    end
  end

  assign w_rxd      = r_rxd_sync[SYNC_STAGES-1];
  assign w_rxc_rise = r_rxc_sync[SYNC_STAGES-1] & ~r_rxc_d;
  assign w_txc_rise = r_txc_sync[SYNC_STAGES-1] & ~r_txc_d;
  assign w_lr       = r_rxtxr_sync[SYNC_STAGES-1];
  assign w_lr_fall  = ~r_rxtxr_sync[SYNC_STAGES-1] & r_rxtxr_d;

  assign w_rx_shift_next = {w_rxd, r_rx_shift[7:1]};

  // Write lane: deserialize bits, emit bytes, track position within the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_bit_cnt  <= '0;
      r_rx_byte_cnt <= '0;
      r_rx_shift    <= '0;
      r_wr_data     <= '0;
      r_wr_valid    <= 1'b0;
      r_wr_last     <= 1'b0;
      r_link_reset  <= 1'b0;
    end else begin
      r_wr_valid   <= 1'b0;
      r_wr_last    <= 1'b0;
      r_link_reset <= w_lr_fall;
      if (w_lr) begin
        r_rx_bit_cnt  <= '0;
        r_rx_byte_cnt <= '0;
        r_rx_shift    <= '0;
      end else if (w_rxc_rise) begin
        r_rx_shift <= w_rx_shift_next;
        if (r_rx_bit_cnt == 3'd7) begin
          r_rx_bit_cnt <= '0;
          r_wr_data    <= w_rx_shift_next;
          r_wr_valid   <= 1'b1;
          r_wr_last    <= (r_rx_byte_cnt == BW'(WORD_BYTES - 1));
          if (r_rx_byte_cnt == BW'(WORD_BYTES - 1)) r_rx_byte_cnt <= '0;
          else r_rx_byte_cnt <= r_rx_byte_cnt + 1'b1;
        end else begin
          r_rx_bit_cnt <= r_rx_bit_cnt + 3'd1;
        end
      end
    end
  end

  // Round-robin pick: req1 wins alone, or on a tie when req0 was granted last.
  assign w_pick1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);

  // Read lane next-state: presence bit on slot start, then 8 data bits LSB-first.
  always_comb begin
    w_tx_state_next   = r_tx_state;
    w_tx_shift_next   = r_tx_shift;
    w_tx_bit_cnt_next = r_tx_bit_cnt;
    w_txd_next        = r_txd;
    w_req0_ready_next = 1'b0;
    w_req1_ready_next = 1'b0;
    w_last_grant_next = r_last_grant;
    if (w_lr) begin
      w_tx_state_next   = TX_IDLE;
      w_tx_bit_cnt_next = '0;
      w_txd_next        = 1'b0;
    end else if (w_txc_rise) begin
      case (r_tx_state)
        TX_IDLE: begin
          if (bus.req0_valid | bus.req1_valid) begin
            if (w_pick1) begin
              w_tx_shift_next   = bus.req1_data;
              w_req1_ready_next = 1'b1;
              w_last_grant_next = 1'b1;
            end else begin
              w_tx_shift_next   = bus.req0_data;
              w_req0_ready_next = 1'b1;
              w_last_grant_next = 1'b0;
            end
            w_txd_next        = 1'b1;
            w_tx_bit_cnt_next = '0;
            w_tx_state_next   = TX_DATA;
          end else begin
            w_txd_next = 1'b0;
          end
        end
        TX_DATA: begin
          w_txd_next        = r_tx_shift[0];
          w_tx_shift_next   = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_cnt_next = r_tx_bit_cnt + 3'd1;
          if (r_tx_bit_cnt == 3'd7) w_tx_state_next = TX_IDLE;
        end
        default: w_tx_state_next = TX_IDLE;
      endcase
    end
  end

  // Read lane state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state   <= TX_IDLE;
      r_tx_shift   <= '0;
      r_tx_bit_cnt <= '0;
      r_txd        <= 1'b0;
      r_req0_ready <= 1'b0;
      r_req1_ready <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_tx_state   <= w_tx_state_next;
      r_tx_shift   <= w_tx_shift_next;
      r_tx_bit_cnt <= w_tx_bit_cnt_next;
      r_txd        <= w_txd_next;
      r_req0_ready <= w_req0_ready_next;
      r_req1_ready <= w_req1_ready_next;
      r_last_grant <= w_last_grant_next;
    end
  end

`ifdef BITBANG_LINK_STATS_EN
  logic [15:0] r_rx_stat, r_tx_stat;

  // Byte statistics; only the system reset clears them, not a link reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_stat <= '0;
      r_tx_stat <= '0;
    end else begin
      if (r_wr_valid) r_rx_stat <= r_rx_stat + 16'd1;
      if (r_req0_ready | r_req1_ready) r_tx_stat <= r_tx_stat + 16'd1;
    end
  end

  assign o_rx_byte_cnt = r_rx_stat;
  assign o_tx_byte_cnt = r_tx_stat;
`endif

  assign o_txd          = r_txd;
  assign o_link_reset   = r_link_reset;
  assign o_tx_state     = r_tx_state;
  assign bus.wr_data    = r_wr_data;
  assign bus.wr_valid   = r_wr_valid;
  assign bus.wr_last    = r_wr_last;
  assign bus.req0_ready = r_req0_ready;
  assign bus.req1_ready = r_req1_ready;

endmodule
